// File: rtl/mlp_conv2d_status_collector.sv
// rtl/mlp_conv2d_status_collector.sv - registered done/error collector for the conv array
module mlp_conv2d_status_collector #(
  parameter int NUM_INST       = 16,
  parameter int PIPE_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 32,
  localparam int DC_W          = $clog2(NUM_INST + 1)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NUM_INST-1:0] i_conv_done,
  input  logic [NUM_INST-1:0] i_error,
  output logic                o_busy,
  output logic                o_conv_done,
  output logic                o_conv_done_oe,
  output logic                o_error,
  output logic                o_error_oe,
  output logic                o_timeout,
  output logic [NUM_INST-1:0] o_done_mask,
  output logic [NUM_INST-1:0] o_error_mask,
  output logic [DC_W-1:0]     o_done_count,
  output logic [CNT_W-1:0]    o_cycle_count
);

  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

  state_t              state, state_nxt;
  logic [NUM_INST-1:0] done_pipe [PIPE_STAGES];
  logic [NUM_INST-1:0] err_pipe  [PIPE_STAGES];
  logic [NUM_INST-1:0] done_p, err_p;
  logic [NUM_INST-1:0] done_mask, done_mask_nxt;
  logic [NUM_INST-1:0] error_mask, error_mask_nxt;
  logic [CNT_W-1:0]    cycle_count, cycle_count_nxt;
  logic                timeout, timeout_nxt;
  logic [DC_W-1:0]     done_count, done_count_nxt;

  // Die-crossing register chain for the per-instance level inputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        done_pipe[s] <= '0;
        err_pipe[s]  <= '0;
      end
    end else begin
      done_pipe[0] <= i_conv_done;
      err_pipe[0]  <= i_error;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        done_pipe[s] <= done_pipe[s-1];
        err_pipe[s]  <= err_pipe[s-1];
      end
    end
  end

  assign done_p = done_pipe[PIPE_STAGES-1];
  assign err_p  = err_pipe[PIPE_STAGES-1];

  // Round FSM: mask accumulation and exit decision; counter only advances while staying in RUN
  always_comb begin
    state_nxt       = state;
    done_mask_nxt   = done_mask;
    error_mask_nxt  = error_mask;
    cycle_count_nxt = cycle_count;
    timeout_nxt     = timeout;
    case (state)
      IDLE, DONE, FAIL: begin
        if (i_start) begin
          state_nxt       = RUN;
          done_mask_nxt   = '0;
          error_mask_nxt  = '0;
          cycle_count_nxt = '0;
          timeout_nxt     = 1'b0;
        end
      end
      RUN: begin
        done_mask_nxt  = done_mask | done_p;
        error_mask_nxt = error_mask | err_p;
        if (|error_mask_nxt) begin
          state_nxt = FAIL;
        end else if (TO_EN && (cycle_count == TO_LAST)) begin
          state_nxt   = FAIL;
          timeout_nxt = 1'b1;
        end else if (&done_mask_nxt) begin
          state_nxt = DONE;
        end else if (cycle_count != '1) begin
          cycle_count_nxt = cycle_count + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Popcount of the next mask so the registered count lines up with the mask itself
  always_comb begin
    done_count_nxt = '0;
    for (int i = 0; i < NUM_INST; i++) begin
      done_count_nxt = done_count_nxt + DC_W'(done_mask_nxt[i]);
    end
  end

  // State and status registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      done_mask   <= '0;
      error_mask  <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
      done_count  <= '0;
    end else begin
      state       <= state_nxt;
      done_mask   <= done_mask_nxt;
      error_mask  <= error_mask_nxt;
      cycle_count <= cycle_count_nxt;
      timeout     <= timeout_nxt;
      done_count  <= done_count_nxt;
    end
  end

  assign o_busy         = (state == RUN);
  assign o_conv_done    = (state == DONE);
  assign o_error        = (state == FAIL);
  assign o_conv_done_oe = 1'b1;
  assign o_error_oe     = 1'b1;
  assign o_timeout      = timeout;
  assign o_done_mask    = done_mask;
  assign o_error_mask   = error_mask;
  assign o_done_count   = done_count;
  assign o_cycle_count  = cycle_count;

endmodule

// File: tb/tb_mlp_conv2d_status_collector.sv
// tb/tb_mlp_conv2d_status_collector.sv - scoreboard bench for the conv status collector
module tb_mlp_conv2d_status_collector;

  localparam int N  = 16;
  localparam int PS = 2;
  localparam int TO = 100;
  localparam int CW = 32;
  localparam int DW = 5;

  typedef logic [74:0] status_t;
  localparam status_t RST_VAL = {6'b000011, 69'b0};

  logic          clk = 1'b0;
  logic          reset, start;
  logic [N-1:0]  cdone, err;
  logic          o_busy, o_conv_done, o_conv_done_oe, o_error, o_error_oe, o_timeout;
  logic [N-1:0]  o_done_mask, o_error_mask;
  logic [DW-1:0] o_done_count;
  logic [CW-1:0] o_cycle_count;

  int checks = 0;
  int errors = 0;
  int stepn  = 0;

  status_t exp_q[$];
  status_t exp_cur;

  int          m_state;
  logic [15:0] m_dm, m_em, m_p0d, m_p1d, m_p0e, m_p1e;
  logic [31:0] m_cnt;
  logic        m_to;

  mlp_conv2d_status_collector #(
    .NUM_INST(N), .PIPE_STAGES(PS), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_conv_done(cdone), .i_error(err),
    .o_busy(o_busy), .o_conv_done(o_conv_done), .o_conv_done_oe(o_conv_done_oe),
    .o_error(o_error), .o_error_oe(o_error_oe), .o_timeout(o_timeout),
    .o_done_mask(o_done_mask), .o_error_mask(o_error_mask),
    .o_done_count(o_done_count), .o_cycle_count(o_cycle_count)
  );

  always #5 clk = ~clk;

  function automatic status_t dut_status();
    return {o_busy, o_conv_done, o_error, o_timeout, o_conv_done_oe, o_error_oe,
            o_done_count, o_done_mask, o_error_mask, o_cycle_count};
  endfunction

  function automatic status_t model_status();
    return {(m_state == 1), (m_state == 2), (m_state == 3), m_to, 1'b1, 1'b1,
            5'($countones(m_dm)), m_dm, m_em, m_cnt};
  endfunction

  // Drive one cycle, advance the reference model, queue its expectation, sample after the edge
  task automatic step(input logic s, input logic r, input logic [15:0] d, input logic [15:0] e);
    logic [15:0] nd, ne;
    start = s; reset = r; cdone = d; err = e;
    if (r) begin
      m_state = 0; m_dm = '0; m_em = '0; m_cnt = '0; m_to = 1'b0;
      m_p0d = '0; m_p1d = '0; m_p0e = '0; m_p1e = '0;
    end else begin
      if (m_state == 1) begin
        nd = m_dm | m_p1d;
        ne = m_em | m_p1e;
        m_dm = nd;
        m_em = ne;
        if (ne != 0) m_state = 3;
        else if (m_cnt == 32'(TO - 1)) begin m_state = 3; m_to = 1'b1; end
        else if (nd == 16'hffff) m_state = 2;
        else if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
      end else if (s) begin
        m_state = 1; m_dm = '0; m_em = '0; m_cnt = '0; m_to = 1'b0;
      end
      m_p1d = m_p0d; m_p0d = d;
      m_p1e = m_p0e; m_p0e = e;
    end
    exp_q.push_back(model_status());
    @(posedge clk);
    #1;
    exp_cur = exp_q.pop_front();
    stepn++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom), 1'b1, 16'($urandom), 16'($urandom));
      checks++;
      if (dut_status() !== RST_VAL) begin
        errors++; $display("FAIL reset_vals step %0d got %h exp %h", stepn, dut_status(), RST_VAL);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, (i < 2) ? 16'hffff : 16'h0000, (i == 1) ? 16'h0010 : 16'h0000);
      checks++;
      if (dut_status() !== exp_cur) begin
        errors++; $display("FAIL idle_pulse step %0d got %h exp %h", stepn, dut_status(), exp_cur);
      end
    end
    checks++;
    if ({o_done_mask, o_error_mask, o_busy} !== 33'h0) begin
      errors++; $display("FAIL idle_masks got %h/%h exp 0/0", o_done_mask, o_error_mask);
    end
  endtask

  task automatic test_normal();
    logic [15:0] lvl = '0;
    int set_idx = -1;
    int rise_idx = -1;
    step(1'b1, 1'b0, lvl, '0);
    checks++;
    if (dut_status() !== exp_cur || o_busy !== 1'b1 || o_cycle_count !== 32'd0) begin
      errors++; $display("FAIL normal_start got %h exp %h", dut_status(), exp_cur);
    end
    for (int c = 1; c <= 30; c++) begin
      if (c >= 5 && c < 21) begin
        lvl[c-5] = 1'b1;
        if (c == 20) set_idx = stepn;
      end
      step(1'b0, 1'b0, lvl, '0);
      checks++;
      if (dut_status() !== exp_cur) begin
        errors++; $display("FAIL normal step %0d got %h exp %h", stepn, dut_status(), exp_cur);
      end
      if (o_conv_done === 1'b1 && rise_idx < 0) begin
        rise_idx = stepn;
        checks++;
        if (o_busy !== 1'b0 || o_done_count !== 5'd16) begin
          errors++; $display("FAIL normal_done_edge busy %b count %0d exp busy 0 count 16", o_busy, o_done_count);
        end
      end
    end
    checks++;
    if (rise_idx < 0 || rise_idx - set_idx != 3) begin
      errors++; $display("FAIL normal_latency got %0d exp 3", rise_idx - set_idx);
    end
  endtask

  task automatic test_restart();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0);
    checks++;
    if (o_busy !== 1'b1 || o_conv_done !== 1'b0 || o_done_mask !== 16'h0 || o_done_count !== 5'd0 || o_cycle_count !== 32'd0) begin
      errors++; $display("FAIL restart_clear got %h exp busy with zero masks", dut_status());
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 16'h00f3, '0);
      checks++;
      if (dut_status() !== exp_cur) begin
        errors++; $display("FAIL restart_run step %0d got %h exp %h", stepn, dut_status(), exp_cur);
      end
    end
    step(1'b1, 1'b1, 16'hffff, 16'h0001);
    checks++;
    if (dut_status() !== RST_VAL) begin
      errors++; $display("FAIL midrun_reset got %h exp %h", dut_status(), RST_VAL);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, '0);
      checks++;
      if (dut_status() !== exp_cur) begin
        errors++; $display("FAIL after_reset step %0d got %h exp %h", stepn, dut_status(), exp_cur);
      end
    end
  endtask

  task automatic test_error();
    logic [15:0] lvl = '0;
    step(1'b1, 1'b0, '0, '0);
    for (int c = 1; c <= 25; c++) begin
      if (c <= 15) lvl[c-1] = 1'b1;
      if (c == 20) lvl[15] = 1'b1;
      step(1'b0, 1'b0, lvl, (c == 10) ? 16'h0080 : 16'h0000);
      checks++;
      if (dut_status() !== exp_cur) begin
        errors++; $display("FAIL error step %0d got %h exp %h", stepn, dut_status(), exp_cur);
      end
    end
    checks++;
    if (o_error !== 1'b1 || o_error_mask !== 16'h0080 || o_timeout !== 1'b0 || o_done_mask[15] !== 1'b0) begin
      errors++; $display("FAIL error_final got err %b emask %h to %b dm15 %b exp 1 0080 0 0",
                         o_error, o_error_mask, o_timeout, o_done_mask[15]);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b0, '0, '0);
    for (int c = 1; c <= 10; c++) begin
      step(1'b0, 1'b0, (c >= 5) ? 16'hffff : 16'h7fff, (c >= 5) ? 16'h0008 : 16'h0000);
      checks++;
      if (dut_status() !== exp_cur) begin
        errors++; $display("FAIL simul step %0d got %h exp %h", stepn, dut_status(), exp_cur);
      end
    end
    checks++;
    if (o_error !== 1'b1 || o_conv_done !== 1'b0 || o_error_mask !== 16'h0008) begin
      errors++; $display("FAIL simul_final got err %b done %b emask %h exp 1 0 0008", o_error, o_conv_done, o_error_mask);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_timeout();
    int busy_idx;
    int fail_idx = -1;
    step(1'b1, 1'b0, 16'h03ff, '0);
    busy_idx = stepn;
    for (int c = 1; c <= 110; c++) begin
      step(1'b0, 1'b0, 16'h03ff, '0);
      checks++;
      if (dut_status() !== exp_cur) begin
        errors++; $display("FAIL timeout step %0d got %h exp %h", stepn, dut_status(), exp_cur);
      end
      if (o_error === 1'b1 && fail_idx < 0) fail_idx = stepn;
    end
    checks++;
    if (fail_idx < 0 || fail_idx - busy_idx != 100 || o_timeout !== 1'b1 || o_cycle_count !== 32'd99) begin
      errors++; $display("FAIL timeout_final got delay %0d to %b cnt %0d exp 100 1 99",
                         fail_idx - busy_idx, o_timeout, o_cycle_count);
    end
  endtask

  initial begin
    m_state = 0; m_dm = '0; m_em = '0; m_cnt = '0; m_to = 1'b0;
    m_p0d = '0; m_p1d = '0; m_p0e = '0; m_p1e = '0;
    start = 1'b0; reset = 1'b1; cdone = '0; err = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_normal();
    test_restart();
    test_error();
    test_simultaneous();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
